// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit multiplexed 7-segment display bus.
// Both the segment encoder and the receive-side decoder import this package.
package seg7_pkg;

    localparam logic [6:0] SEG_D0     = 7'h3F;
    localparam logic [6:0] SEG_D1     = 7'h06;
    localparam logic [6:0] SEG_D2     = 7'h5B;
    localparam logic [6:0] SEG_D3     = 7'h4F;
    localparam logic [6:0] SEG_D4     = 7'h66;
    localparam logic [6:0] SEG_D5     = 7'h6D;
    localparam logic [6:0] SEG_D6     = 7'h7D;
    localparam logic [6:0] SEG_D7     = 7'h27;
    localparam logic [6:0] SEG_D8     = 7'h7F;
    localparam logic [6:0] SEG_D9     = 7'h6F;
    localparam logic [6:0] SEG_D9_ALT = 7'h67;

    localparam logic CA_ONES = 1'b0;
    localparam logic CA_TENS = 1'b1;

    typedef enum logic [1:0] {
        WAIT_BOTH = 2'd0,
        HAVE_ONES = 2'd1,
        HAVE_TENS = 2'd2
    } rx_state_t;

    // tens*10 + ones using shifts only; the largest result is 99.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens_d,
                                              input logic [3:0] ones_d);
        return {tens_d, 3'b000} + {2'b00, tens_d, 1'b0} + {3'b000, ones_d};
    endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Exact-match decode of a 7-segment pattern (bit0 = a ... bit6 = g) to BCD.
// Any pattern not in the table, including all-off, is reported as illegal.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] digit
);

    // NOTE: both outputs get a default before the case so no latch is inferred.
    always_comb begin
        legal = 1'b1;
        digit = 4'd0;
        case (pattern)
            SEG_D0:             digit = 4'd0;
            SEG_D1:             digit = 4'd1;
            SEG_D2:             digit = 4'd2;
            SEG_D3:             digit = 4'd3;
            SEG_D4:             digit = 4'd4;
            SEG_D5:             digit = 4'd5;
            SEG_D6:             digit = 4'd6;
            SEG_D7:             digit = 4'd7;
            SEG_D8:             digit = 4'd8;
            SEG_D9, SEG_D9_ALT: digit = 4'd9;
            default:            legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_rx.sv
// Receive-side decoder for the multiplexed two-digit 7-segment bus: synchronize,
// glitch-filter, decode each stable pattern and assemble the tens/ones value.
module seg7_rx
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       ca_in,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [6:0] value,
    output logic       value_valid,
    output logic       err,
    output logic       locked
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_last;
    logic [3:0] r_run;
    rx_state_t  r_state;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic [6:0] r_value;
    logic       r_valid;
    logic       r_err;
    logic       r_locked;

    logic       w_same;
    logic [3:0] w_run_next;
    logic       w_accept;
    logic       w_ca;
    logic       w_legal;
    logic [3:0] w_digit;
    rx_state_t  w_state_next;
    logic       w_ld_ones;
    logic       w_ld_tens;
    logic       w_fire;
    logic [3:0] w_new_ones;
    logic [3:0] w_new_tens;

    // NOTE: sequential state uses non-blocking assignments with an async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {ca_in, seg_in};
            r_sync2 <= r_sync1;
        end
    end

    // The run length includes the current cycle; accept once when it first hits the limit.
    assign w_same     = (r_sync2 == r_last);
    assign w_run_next = !w_same ? 4'd1 : ((r_run == RUN_MAX) ? r_run : r_run + 4'd1);
    assign w_accept   = (w_run_next == RUN_MAX) && (!w_same || (r_run != RUN_MAX));
    assign w_ca       = r_sync2[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= '0;
            r_run  <= '0;
        end else begin
            r_last <= r_sync2;
            r_run  <= w_run_next;
        end
    end

    seg7_pattern_dec u_dec (
        .pattern (r_sync2[6:0]),
        .legal   (w_legal),
        .digit   (w_digit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= WAIT_BOTH;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ld_ones    = 1'b0;
        w_ld_tens    = 1'b0;
        w_fire       = 1'b0;
        if (w_accept && w_legal) begin
            w_ld_ones = (w_ca == CA_ONES);
            w_ld_tens = (w_ca == CA_TENS);
            case (r_state)
                WAIT_BOTH: w_state_next = (w_ca == CA_TENS) ? HAVE_TENS : HAVE_ONES;
                HAVE_ONES: begin
                    if (w_ca == CA_TENS) begin
                        w_state_next = WAIT_BOTH;
                        w_fire       = 1'b1;
                    end
                end
                HAVE_TENS: begin
                    if (w_ca == CA_ONES) begin
                        w_state_next = WAIT_BOTH;
                        w_fire       = 1'b1;
                    end
                end
                default: w_state_next = WAIT_BOTH;
            endcase
        end
    end

    assign w_new_ones = w_ld_ones ? w_digit : r_ones;
    assign w_new_tens = w_ld_tens ? w_digit : r_tens;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones   <= '0;
            r_tens   <= '0;
            r_value  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_ones  <= w_new_ones;
            r_tens  <= w_new_tens;
            r_valid <= w_fire;
            r_err   <= w_accept && !w_legal;
            if (w_fire) r_value <= bcd_to_bin(w_new_tens, w_new_ones);
            if (w_accept && !w_legal) r_locked <= 1'b0;
            else if (w_fire)          r_locked <= 1'b1;
        end
    end

    assign ones        = r_ones;
    assign tens        = r_tens;
    assign value       = r_value;
    assign value_valid = r_valid;
    assign err         = r_err;
    assign locked      = r_locked;

endmodule

// File: tb/tb_seg7_rx.sv
// Scenario bench for seg7_rx: expected tens/ones/value triples are queued when the
// completing digit is driven and popped whenever value_valid strobes.
module tb_seg7_rx;
    import seg7_pkg::*;

    localparam int S = 4;

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [6:0] value;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic       ca_in = 1'b0;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [6:0] value;
    logic       value_valid;
    logic       err;
    logic       locked;

    seg7_rx #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .ca_in       (ca_in),
        .ones        (ones),
        .tens        (tens),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   valid_cnt = 0;
    int   err_cnt   = 0;
    int   valid_cyc = -1;
    exp_t sb_q[$];
    logic [6:0] seg_tab [10];

    // One clock; outputs sampled 1 time unit after the edge and scoreboard drained on strobes.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (err) err_cnt++;
        if (value_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: value_valid with tens=%0d ones=%0d value=%0d, none queued",
                         tens, ones, value);
            end else begin
                e = sb_q.pop_front();
                if ({tens, ones, value} !== {e.tens, e.ones, e.value}) begin
                    failures++;
                    $display("FAIL sb_value: got tens=%0d ones=%0d value=%0d, want tens=%0d ones=%0d value=%0d",
                             tens, ones, value, e.tens, e.ones, e.value);
                end
            end
        end
    endtask

    task automatic hold(input logic ca, input logic [6:0] seg, input int n);
        ca_in  = ca;
        seg_in = seg;
        repeat (n) tick();
    endtask

    task automatic expect_pair(input int t, input int o);
        exp_t e;
        e.tens  = 4'(t);
        e.ones  = 4'(o);
        e.value = 7'(t * 10 + o);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        ca_in  = CA_ONES;
        seg_in = 7'h4F;
        repeat (3) tick();
        checks++;
        if ({ones, tens, value, value_valid, err, locked} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got ones=%0d tens=%0d value=%0d vv=%b err=%b locked=%b, want all 0",
                     ones, tens, value, value_valid, err, locked);
        end
        checks++;
        if (dut.r_state !== WAIT_BOTH) begin
            failures++;
            $display("FAIL reset_state: got %0d want WAIT_BOTH", dut.r_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int v0, c0;
        hold(CA_ONES, 7'h4F, 10);
        checks++;
        if (ones !== 4'd3 || valid_cnt !== 0 || err_cnt !== 0) begin
            failures++;
            $display("FAIL basic_ones: got ones=%0d valids=%0d errs=%0d, want 3/0/0", ones, valid_cnt, err_cnt);
        end
        v0 = valid_cnt;
        c0 = cyc;
        expect_pair(1, 3);
        hold(CA_TENS, 7'h06, 10);
        checks++;
        if (valid_cnt !== v0 + 1) begin
            failures++;
            $display("FAIL basic_strobe_count: got %0d want %0d", valid_cnt - v0, 1);
        end
        checks++;
        if (valid_cyc !== c0 + 1 + 1 + S) begin
            failures++;
            $display("FAIL basic_latency: strobe after edge %0d, want edge %0d", valid_cyc - c0, 2 + S);
        end
        checks++;
        if (value !== 7'd13 || locked !== 1'b1) begin
            failures++;
            $display("FAIL basic_value: got value=%0d locked=%b, want 13/1", value, locked);
        end
    endtask

    task automatic test_illegal();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        hold(CA_ONES, 7'h49, 10);
        checks++;
        if (err_cnt !== e0 + 1) begin
            failures++;
            $display("FAIL illegal_err_count: got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (locked !== 1'b0 || value !== 7'd13 || ones !== 4'd3 || valid_cnt !== v0) begin
            failures++;
            $display("FAIL illegal_hold: got locked=%b value=%0d ones=%0d new_valids=%0d, want 0/13/3/0",
                     locked, value, ones, valid_cnt - v0);
        end
        checks++;
        if (dut.r_state !== WAIT_BOTH) begin
            failures++;
            $display("FAIL illegal_state: got %0d want WAIT_BOTH", dut.r_state);
        end
    endtask

    task automatic test_glitch();
        int v0, e0;
        hold(CA_ONES, 7'h3F, 10);
        v0 = valid_cnt;
        e0 = err_cnt;
        hold(CA_ONES, 7'h66, S - 1);
        hold(CA_ONES, 7'h3F, 10);
        checks++;
        if (ones !== 4'd0 || err_cnt !== e0 || valid_cnt !== v0) begin
            failures++;
            $display("FAIL glitch: got ones=%0d new_errs=%0d new_valids=%0d, want 0/0/0",
                     ones, err_cnt - e0, valid_cnt - v0);
        end
    endtask

    task automatic test_alt_nine();
        int v0;
        do_reset();
        v0 = valid_cnt;
        hold(CA_TENS, 7'h3F, 10);
        expect_pair(0, 9);
        hold(CA_ONES, 7'h67, 10);
        checks++;
        if (valid_cnt !== v0 + 1 || value !== 7'd9 || ones !== 4'd9 || tens !== 4'd0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL alt_nine: got valids=%0d value=%0d ones=%0d tens=%0d locked=%b, want 1/9/9/0/1",
                     valid_cnt - v0, value, ones, tens, locked);
        end
    endtask

    task automatic test_long_hold();
        int v0, e0;
        do_reset();
        v0 = valid_cnt;
        e0 = err_cnt;
        hold(CA_ONES, 7'h06, 10);
        hold(CA_ONES, 7'h5B, 10);
        expect_pair(1, 2);
        hold(CA_TENS, 7'h06, 100);
        checks++;
        if (valid_cnt !== v0 + 1 || value !== 7'd12 || err_cnt !== e0) begin
            failures++;
            $display("FAIL long_hold: got valids=%0d value=%0d errs=%0d, want 1/12/0",
                     valid_cnt - v0, value, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        do_reset();
        hold(CA_ONES, 7'h7F, 10);
        checks++;
        if (ones !== 4'd8) begin
            failures++;
            $display("FAIL mid_pre_reset: got ones=%0d want 8", ones);
        end
        do_reset();
        checks++;
        if (ones !== 4'd0 || dut.r_state !== WAIT_BOTH) begin
            failures++;
            $display("FAIL mid_reset_clear: got ones=%0d state=%0d, want 0/WAIT_BOTH", ones, dut.r_state);
        end
        v0 = valid_cnt;
        hold(CA_TENS, 7'h06, 10);
        checks++;
        if (tens !== 4'd1 || ones !== 4'd0 || valid_cnt !== v0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL mid_tens_only: got tens=%0d ones=%0d valids=%0d locked=%b, want 1/0/0/0",
                     tens, ones, valid_cnt - v0, locked);
        end
        expect_pair(1, 5);
        hold(CA_ONES, 7'h6D, 10);
        checks++;
        if (value !== 7'd15 || valid_cnt !== v0 + 1) begin
            failures++;
            $display("FAIL mid_value: got value=%0d valids=%0d, want 15/1", value, valid_cnt - v0);
        end
    endtask

    task automatic test_back_to_back();
        int v0, e0, t, o;
        do_reset();
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            t = int'($urandom_range(0, 9));
            o = int'($urandom_range(0, 9));
            expect_pair(t, o);
            hold(CA_ONES, seg_tab[o], S);
            hold(CA_TENS, seg_tab[t], S);
        end
        repeat (S + 4) tick();
        checks++;
        if (valid_cnt !== v0 + 4 || err_cnt !== e0) begin
            failures++;
            $display("FAIL back_to_back: got valids=%0d errs=%0d, want 4/0", valid_cnt - v0, err_cnt - e0);
        end
    endtask

    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h27;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

        test_reset();
        test_basic();
        test_illegal();
        test_glitch();
        test_alt_nine();
        test_long_hold();
        test_reset_mid();
        test_back_to_back();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d expected values never produced, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_rx.md
# seg7_rx

Receive-side decoder for the two-digit multiplexed 7-segment display bus. It samples the segment lines and the digit-select line, rejects short glitches, and decodes each stable segment pattern back to a BCD digit. Once it holds both ones and tens digits, it presents the binary value with a one-cycle strobe. It sits on the board's display-snoop path, or in a loopback bench opposite the segment encoder, and recovers the number being shown.

## Interface
Parameters:
- STABLE_CYCLES, default 4: consecutive identical synchronized samples required to accept a pattern; legal range 1..15.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset, asynchronous and active-high.
- seg_in  input  7  segment lines, active-high; bit0 = segment a … bit6 = segment g.
- ca_in  input  1  digit select; 0 = ones digit, 1 = tens digit.
- ones  output  4  last accepted ones digit, BCD.
- tens  output  4  last accepted tens digit, BCD.
- value  output  7  tens*10 + ones, range 0..99.
- value_valid  output  1  one-cycle strobe when value updates.
- err  output  1  one-cycle strobe when an illegal pattern is accepted.
- locked  output  1  high after the first value_valid; cleared by err or rst.

## Operation
- seg_in and ca_in pass through a 2-flop synchronizer, 8 bits wide; reset value 0.
- Stability filter:
  - The run counter counts consecutive cycles in which the synchronized {ca,seg} is unchanged; it saturates at STABLE_CYCLES.
  - Any change restarts the run.
  - An accept pulse fires exactly once per run, when the count reaches STABLE_CYCLES. A run held indefinitely gives no further accepts.
  - The first run after reset is always eligible, whatever the pre-reset input.
- Pattern decode, exact match:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x27→7, 0x7F→8.
  - 0x6F→9, and 0x67→9 (alternate form).
  - Every other pattern, including 0x00, is illegal.
- On an illegal accept:
  - err pulses and locked clears.
  - ones, tens, value and the FSM state are unchanged.
- FSM with states WAIT_BOTH, HAVE_ONES and HAVE_TENS; reset state is WAIT_BOTH. On a legal accept:
  - WAIT_BOTH, ca=0: load ones, go to HAVE_ONES.
  - WAIT_BOTH, ca=1: load tens, go to HAVE_TENS.
  - HAVE_ONES, ca=0: overwrite ones, stay in HAVE_ONES.
  - HAVE_ONES, ca=1: load tens, go to WAIT_BOTH, pulse value_valid, set locked.
  - HAVE_TENS, ca=1: overwrite tens, stay in HAVE_TENS.
  - HAVE_TENS, ca=0: load ones, go to WAIT_BOTH, pulse value_valid, set locked.
- Arithmetic: value = {tens,3'b0} + {tens,1'b0} + ones, computed at 7 bits from the newly loaded digits. No overflow is possible, since the maximum is 99.
- Reset mid-operation: all state and outputs return to their reset values immediately. A partially captured digit pair is discarded.

## Timing
- Reset values: ones=0, tens=0, value=0, value_valid=0, err=0, locked=0, FSM=WAIT_BOTH.
- Define N as the edge at which the first synchronizer flop first captures a new {ca,seg}, with the inputs held constant from then on.
- The accept-driven registers all update at edge N+1+STABLE_CYCLES: ones/tens, err, value, value_valid and locked.
- Strobes are high for exactly the one cycle after that edge.
- A pattern held for fewer than STABLE_CYCLES synchronized cycles causes no output activity.
- Throughput: at most one accept per STABLE_CYCLES cycles. value_valid can repeat every other accept.

## Structure
- Shared package/include seg7_pkg:
  - Pattern constants SEG_D0..SEG_D9 and SEG_D9_ALT.
  - FSM state encodings.
  - Digit-select constants CA_ONES=0 and CA_TENS=1.
  - The encoder side uses the same constants.
- One combinational sub-module, seg7_pattern_dec: input 7-bit pattern; outputs legal (1 bit) and digit (4 bits).
- The synchronizer, filter, FSM and value register sit in seg7_rx.

## Test plan
All scenarios run with STABLE_CYCLES=4 and a 10-cycle hold unless stated.
1. Reset, then ca=0/0x4F followed by ca=1/0x06 → ones=3, tens=1, value=13, value_valid exactly once, at edge N+5 of the tens pattern; locked=1.
2. Glitch rejection: stable ca=0/0x3F, then ca=0/0x66 for 3 cycles, then back to 0x3F → ones stays 0, no err, no value_valid.
3. Illegal pattern: after scenario 1, ca=0/0x49 → single err pulse, locked=0, value stays 13, FSM stays WAIT_BOTH.
4. Alternate nine: ca=1/0x3F then ca=0/0x67 → tens=0, ones=9, value=9, value_valid once.
5. Overwrite and long hold: ca=0/0x06, then ca=0/0x5B, then ca=1/0x06 held 100 cycles → value=12 with one strobe only; no re-accept during the hold.
6. Reset mid-operation: ca=0/0x7F accepted, rst pulsed, then ca=1/0x06 → tens=1, ones=0, no value_valid until a subsequent ones accept. After ca=0/0x6D: value=15.
